// File: rtl/counter.sv
// Seconds stopwatch core: prescales clk to a 1 Hz tick and counts 00..59 in BCD.
// Optional feature macro: COUNTER_WRAP_OUT_EN adds the registered wrap_pulse output.
module counter #(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       init_regs,
    input  logic       count_enabled,
    output logic [7:0] time_reading
`ifdef COUNTER_WRAP_OUT_EN
    ,
    output logic       wrap_pulse
`endif
);

    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_FREQ - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic          w_tick;
    logic          w_at_59;
    logic [3:0]    w_ones_nxt;
    logic [3:0]    w_tens_nxt;

    assign w_tick  = count_enabled && (r_presc == P_LAST);
    assign w_at_59 = (r_ones == 4'd9) && (r_tens == 4'd5);

    always_comb begin
        w_ones_nxt = r_ones;
        w_tens_nxt = r_tens;
        if (r_ones != 4'd9) begin
            w_ones_nxt = r_ones + 4'd1;
        end else begin
            w_ones_nxt = '0;
            w_tens_nxt = (r_tens == 4'd5) ? '0 : r_tens + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (init_regs) begin
            r_presc <= '0;
            r_ones  <= '0;
            r_tens  <= '0;
        end else if (count_enabled) begin
            if (w_tick) begin
                r_presc <= '0;
                r_ones  <= w_ones_nxt;
                r_tens  <= w_tens_nxt;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign time_reading = {r_tens, r_ones};

`ifdef COUNTER_WRAP_OUT_EN
    logic r_wrap;

    always_ff @(posedge clk) begin
        if (init_regs) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tick && w_at_59;
        end
    end

    assign wrap_pulse = r_wrap;
`else
    logic w_unused;
    assign w_unused = w_at_59;
`endif

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter (CLK_FREQ=10 main instance, CLK_FREQ=1 boundary instance).
module tb_counter;

    logic       clk;
    logic       init_regs;
    logic       count_enabled;
    logic [7:0] time_reading;
    logic [7:0] time_reading_f1;
    logic       wrap_pulse;
    logic       wrap_pulse_f1;

    int unsigned n_vec;
    int unsigned n_err;

    counter #(.CLK_FREQ(10)) dut (
        .clk           (clk),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .time_reading  (time_reading)
`ifdef COUNTER_WRAP_OUT_EN
        ,
        .wrap_pulse    (wrap_pulse)
`endif
    );

    counter #(.CLK_FREQ(1)) dut_f1 (
        .clk           (clk),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .time_reading  (time_reading_f1)
`ifdef COUNTER_WRAP_OUT_EN
        ,
        .wrap_pulse    (wrap_pulse_f1)
`endif
    );

`ifndef COUNTER_WRAP_OUT_EN
    assign wrap_pulse    = 1'b0;
    assign wrap_pulse_f1 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned p;
        int unsigned s;
        logic [7:0]  exp_bcd;
        logic        bcd_ok;

        n_vec         = 0;
        n_err         = 0;
        init_regs     = 1'b1;
        count_enabled = 1'b0;

        // Reset held for two edges
        step(2);
        check8("reset_f10", time_reading, 8'h00);
        check8("reset_f1", time_reading_f1, 8'h00);
`ifdef COUNTER_WRAP_OUT_EN
        check1("reset_wrap", wrap_pulse, 1'b0);
`endif

        // First second takes a full 10 enabled edges
        init_regs     = 1'b0;
        count_enabled = 1'b1;
        step(9);
        check8("edge9", time_reading, 8'h00);
        check8("f1_edge9", time_reading_f1, 8'h09);
        step(1);
        check8("edge10", time_reading, 8'h01);
        check8("f1_edge10", time_reading_f1, 8'h10);
        step(10);
        check8("edge20", time_reading, 8'h02);
        check8("f1_edge20", time_reading_f1, 8'h20);

        // Up to 59, then wrap
        step(570);
        check8("edge590", time_reading, 8'h59);
        check1("wrap_low_at59", wrap_pulse, 1'b0);
        step(9);
        check8("edge599", time_reading, 8'h59);
        step(1);
        check8("edge600_wrap", time_reading, 8'h00);
`ifdef COUNTER_WRAP_OUT_EN
        check1("wrap_high", wrap_pulse, 1'b1);
`endif
        step(1);
        check8("after_wrap", time_reading, 8'h00);
        check1("wrap_low_after", wrap_pulse, 1'b0);

        // Pause five edges into a second
        step(4);
        count_enabled = 1'b0;
        step(50);
        check8("paused", time_reading, 8'h00);
        check1("wrap_low_paused", wrap_pulse, 1'b0);
        count_enabled = 1'b1;
        step(4);
        check8("resume4", time_reading, 8'h00);
        step(1);
        check8("resume5", time_reading, 8'h01);

        // Reset mid-second at 37 while enabled
        step(360);
        check8("at37", time_reading, 8'h37);
        step(3);
        init_regs = 1'b1;
        step(1);
        check8("reset_at37", time_reading, 8'h00);
        init_regs = 1'b0;
        step(9);
        check8("post_reset9", time_reading, 8'h00);
        step(1);
        check8("post_reset10", time_reading, 8'h01);

        // 700-edge run against a reference model with BCD range checks
        p = 0;
        s = 1;
        for (int unsigned i = 0; i < 700; i++) begin
            step(1);
            p++;
            if (p == 10) begin
                p = 0;
                s = (s + 1) % 60;
            end
            exp_bcd = {4'(s / 10), 4'(s % 10)};
            check8("run_model", time_reading, exp_bcd);
            bcd_ok = (time_reading[3:0] <= 4'd9) && (time_reading[7:4] <= 4'd5);
            check1("run_bcd_range", bcd_ok, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
